// File: rtl/parser_pkg.sv
// Shared types and constants for the receive parser chain.
package parser_pkg;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam int          ETH_HDR_LEN  = 14;
  localparam logic [3:0]  IPV4_MIN_IHL = 4'd5;
  localparam logic [3:0]  IPV4_VERSION = 4'd4;

  typedef enum logic [1:0] {
    S_ETH,
    S_HDR,
    S_DONE
  } ipv4_state_t;

  // Fold the end-around carry of a 20-bit ones-complement sum twice.
  function automatic logic [15:0] csum_fold(input logic [19:0] raw);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, raw[15:0]} + {13'd0, raw[19:16]};
    s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
    return s2[15:0];
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// Per-beat ones-complement accumulator for Internet checksums.
// Each enabled lane adds its byte either as the high (even position) or low
// (odd position) half of a 16-bit word. o_sum_ok reflects the sum including
// the current beat, so a result can be taken in the same cycle.
module ipv4_csum_acc
  import parser_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_lane_en,
  input  logic [DATA_WIDTH/8-1:0] i_lane_odd,
  output logic                    o_sum_ok
);

  localparam int NB = DATA_WIDTH / 8;

  logic [19:0] r_acc;
  logic [19:0] w_beat_sum;
  logic [19:0] w_raw;
  logic [16:0] w_fold1;

  // Sum of all enabled lanes of this beat, placed at their word position
  always_comb begin
    w_beat_sum = '0;
    for (int k = 0; k < NB; k++) begin
      if (i_lane_en[k]) begin
        if (i_lane_odd[k]) w_beat_sum = w_beat_sum + {12'd0, i_data[k*8 +: 8]};
        else               w_beat_sum = w_beat_sum + {4'd0, i_data[k*8 +: 8], 8'd0};
      end
    end
  end

  assign w_raw    = r_acc + w_beat_sum;
  // Folding once per beat keeps the stored value near 17 bits, so long
  // headers never overflow the 20-bit accumulator.
  assign w_fold1  = {1'b0, w_raw[15:0]} + {13'd0, w_raw[19:16]};
  assign o_sum_ok = (csum_fold(w_raw) == 16'hFFFF);

  // Accumulator register; clear wins over a same-cycle add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_acc <= '0;
    else if (i_clr)          r_acc <= '0;
    else if (|i_lane_en)     r_acc <= {3'd0, w_fold1};
  end

endmodule

// File: rtl/ipv4_parser.sv
// IPv4 header extraction stage behind the Ethernet header parser.
//
// state  | meaning
// S_ETH  | skipping Ethernet header bytes 0..13
// S_HDR  | capturing IPv4 header bytes, accumulating checksum
// S_DONE | header complete, waiting for end of frame
module ipv4_parser
  import parser_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0]  idx_in,
  input  logic [DATA_WIDTH-1:0]              tdata_in,
  input  logic                               data_valid_in,
  input  logic                               last_flag_in,
  input  logic                               eth_parser_ready,
  input  logic [15:0]                        eth_type,
  output logic [DATA_WIDTH-1:0]              tdata_out,
  output logic [$clog2(DATA_WIDTH/8+1)-1:0]  idx_out,
  output logic                               data_valid_out,
  output logic                               last_flag_out,
  output logic                               ipv4_parser_ready,
  output logic                               ipv4_hdr_err,
  output logic [3:0]                         ihl,
  output logic [15:0]                        total_length,
  output logic [7:0]                         ttl,
  output logic [7:0]                         protocol,
  output logic                               more_frag,
  output logic [12:0]                        frag_offset,
  output logic [31:0]                        src_ip,
  output logic [31:0]                        dst_ip
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int IDXW = $clog2(NB + 1);

  ipv4_state_t r_state, w_state, w_state_nxt;

  logic [6:0]  r_byte_cnt;
  logic        r_is_ipv4;

  // Header fields captured so far in the current frame
  logic [3:0]  r_cap_ver,   w_ver;
  logic [3:0]  r_cap_ihl,   w_ihl;
  logic [15:0] r_cap_tlen,  w_tlen;
  logic [7:0]  r_cap_ttl,   w_ttl;
  logic [7:0]  r_cap_proto, w_proto;
  logic        r_cap_mf,    w_mf;
  logic [12:0] r_cap_frag,  w_frag;
  logic [31:0] r_cap_src,   w_src;
  logic [31:0] r_cap_dst,   w_dst;

  logic [6:0]  w_off;
  logic [6:0]  w_h;
  logic [6:0]  w_lim;
  logic [7:0]  w_byte;
  logic [NB-1:0] w_lane_en;
  logic [NB-1:0] w_lane_odd;
  logic        w_complete;
  logic        w_frame_end;
  logic        w_ipv4_now;
  logic        w_trunc;
  logic        w_sum_ok;
  logic        w_hdr_bad;

  logic [DATA_WIDTH-1:0] r_tdata_out;
  logic [IDXW-1:0]       r_idx_out;
  logic                  r_data_valid_out;
  logic                  r_last_flag_out;
  logic                  r_ready;
  logic                  r_err;
  logic [3:0]            r_ihl;
  logic [15:0]           r_tlen;
  logic [7:0]            r_ttl;
  logic [7:0]            r_proto;
  logic                  r_mf;
  logic [12:0]           r_frag;
  logic [31:0]           r_src;
  logic [31:0]           r_dst;

  assign w_frame_end = data_valid_in & last_flag_in;
  assign w_ipv4_now  = r_is_ipv4 | (eth_parser_ready & (eth_type == ETHTYPE_IPV4));

  // Walk the beat lane by lane: a beat may cross the Ethernet/IPv4 boundary
  // and may also contain the end of the header, after which lanes are ignored.
  always_comb begin
    w_state    = r_state;
    w_ver      = r_cap_ver;
    w_ihl      = r_cap_ihl;
    w_tlen     = r_cap_tlen;
    w_ttl      = r_cap_ttl;
    w_proto    = r_cap_proto;
    w_mf       = r_cap_mf;
    w_frag     = r_cap_frag;
    w_src      = r_cap_src;
    w_dst      = r_cap_dst;
    w_off      = '0;
    w_h        = '0;
    w_lim      = '0;
    w_byte     = '0;
    w_lane_en  = '0;
    w_lane_odd = '0;
    w_complete = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (data_valid_in && (IDXW'(k) < idx_in)) begin
        w_off = r_byte_cnt + 7'(k);
        if (w_state == S_ETH && w_off >= 7'(ETH_HDR_LEN)) w_state = S_HDR;
        if (w_state == S_HDR) begin
          w_h           = w_off - 7'(ETH_HDR_LEN);
          w_byte        = tdata_in[k*8 +: 8];
          w_lane_en[k]  = 1'b1;
          w_lane_odd[k] = w_h[0];
          case (w_h)
            7'd0:  begin w_ver = w_byte[7:4]; w_ihl = w_byte[3:0]; end
            7'd2:  w_tlen[15:8]  = w_byte;
            7'd3:  w_tlen[7:0]   = w_byte;
            7'd6:  begin w_mf = w_byte[5]; w_frag[12:8] = w_byte[4:0]; end
            7'd7:  w_frag[7:0]   = w_byte;
            7'd8:  w_ttl         = w_byte;
            7'd9:  w_proto       = w_byte;
            7'd12: w_src[31:24]  = w_byte;
            7'd13: w_src[23:16]  = w_byte;
            7'd14: w_src[15:8]   = w_byte;
            7'd15: w_src[7:0]    = w_byte;
            7'd16: w_dst[31:24]  = w_byte;
            7'd17: w_dst[23:16]  = w_byte;
            7'd18: w_dst[15:8]   = w_byte;
            7'd19: w_dst[7:0]    = w_byte;
            default: ;
          endcase
          // An IHL below the minimum still consumes a 20-byte header
          w_lim = (w_ihl < IPV4_MIN_IHL) ? 7'd19 : ({1'b0, w_ihl, 2'b00} - 7'd1);
          if (w_h == w_lim) begin
            w_state    = S_DONE;
            w_complete = 1'b1;
          end
        end
      end
    end
    w_state_nxt = w_frame_end ? S_ETH : w_state;
  end

  assign w_trunc   = w_frame_end & (w_state == S_HDR) & w_ipv4_now;
  assign w_hdr_bad = (w_ver != IPV4_VERSION) | (w_ihl < IPV4_MIN_IHL) | ~w_sum_ok;

  ipv4_csum_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_csum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_frame_end),
    .i_data     (tdata_in),
    .i_lane_en  (w_lane_en),
    .i_lane_odd (w_lane_odd),
    .o_sum_ok   (w_sum_ok)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ETH;
    else        r_state <= w_state_nxt;
  end

  // Byte offset, sticky IPv4 flag and partial header capture; all restart at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      r_byte_cnt  <= '0;
      r_is_ipv4   <= 1'b0;
      r_cap_ver   <= '0;
      r_cap_ihl   <= '0;
      r_cap_tlen  <= '0;
      r_cap_ttl   <= '0;
      r_cap_proto <= '0;
      r_cap_mf    <= 1'b0;
      r_cap_frag  <= '0;
      r_cap_src   <= '0;
      r_cap_dst   <= '0;
    end else if (w_frame_end) begin
      r_byte_cnt  <= '0;
      r_is_ipv4   <= 1'b0;
      r_cap_ver   <= '0;
      r_cap_ihl   <= '0;
      r_cap_tlen  <= '0;
      r_cap_ttl   <= '0;
      r_cap_proto <= '0;
      r_cap_mf    <= 1'b0;
      r_cap_frag  <= '0;
      r_cap_src   <= '0;
      r_cap_dst   <= '0;
    end else begin
      if (data_valid_in) r_byte_cnt <= r_byte_cnt + 7'(idx_in);
      r_is_ipv4   <= w_ipv4_now;
      r_cap_ver   <= w_ver;
      r_cap_ihl   <= w_ihl;
      r_cap_tlen  <= w_tlen;
      r_cap_ttl   <= w_ttl;
      r_cap_proto <= w_proto;
      r_cap_mf    <= w_mf;
      r_cap_frag  <= w_frag;
      r_cap_src   <= w_src;
      r_cap_dst   <= w_dst;
    end
  end

  // One-cycle registered copy of the input stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdata_out      <= '0;
      r_idx_out        <= '0;
      r_data_valid_out <= 1'b0;
      r_last_flag_out  <= 1'b0;
    end else begin
      r_tdata_out      <= tdata_in;
      r_idx_out        <= idx_in;
      r_data_valid_out <= data_valid_in;
      r_last_flag_out  <= last_flag_in;
    end
  end

  // Result: set on completion or truncation, held through the forwarded last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_ihl   <= '0;
      r_tlen  <= '0;
      r_ttl   <= '0;
      r_proto <= '0;
      r_mf    <= 1'b0;
      r_frag  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
    end else begin
      if (r_last_flag_out) begin
        r_ready <= 1'b0;
        r_err   <= 1'b0;
        r_ihl   <= '0;
        r_tlen  <= '0;
        r_ttl   <= '0;
        r_proto <= '0;
        r_mf    <= 1'b0;
        r_frag  <= '0;
        r_src   <= '0;
        r_dst   <= '0;
      end
      if ((w_complete && w_ipv4_now) || w_trunc) begin
        r_ready <= 1'b1;
        r_err   <= w_trunc | w_hdr_bad;
        r_ihl   <= w_ihl;
        r_tlen  <= w_tlen;
        r_ttl   <= w_ttl;
        r_proto <= w_proto;
        r_mf    <= w_mf;
        r_frag  <= w_frag;
        r_src   <= w_src;
        r_dst   <= w_dst;
      end
    end
  end

  assign tdata_out         = r_tdata_out;
  assign idx_out           = r_idx_out;
  assign data_valid_out    = r_data_valid_out;
  assign last_flag_out     = r_last_flag_out;
  assign ipv4_parser_ready = r_ready;
  assign ipv4_hdr_err      = r_err;
  assign ihl               = r_ihl;
  assign total_length      = r_tlen;
  assign ttl               = r_ttl;
  assign protocol          = r_proto;
  assign more_frag         = r_mf;
  assign frag_offset       = r_frag;
  assign src_ip            = r_src;
  assign dst_ip            = r_dst;

endmodule
